// File: rtl/taxi_pkg.sv
// Shared taxi-meter definitions: trip state codes and default BCD tariff constants.
package taxi_pkg;

    localparam int unsigned FARE_W       = 12;
    localparam int unsigned STALL_W      = 24;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned SECS_PER_MIN = 60;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    localparam logic [FARE_W-1:0] DEF_DAY_RATE   = 12'h020;
    localparam logic [FARE_W-1:0] DEF_NIGHT_RATE = 12'h030;
    localparam logic [FARE_W-1:0] DEF_START_FARE = 12'h100;

endpackage

// File: rtl/wheel_sync.sv
// Wheel sensor conditioning: 2-FF synchroniser, rising-edge detect and
// modulo-PULSES_PER_10M edge counter producing the 10 m strobe.
module wheel_sync #(
    parameter int unsigned PULSES_PER_10M = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wheel_raw,
    input  logic count_en,
    input  logic cnt_clr,
    output logic wheel_edge_c,
    output logic ten_meter_pulse
);

    localparam int unsigned CNT_W = (PULSES_PER_10M > 1) ? $clog2(PULSES_PER_10M) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSES_PER_10M - 1);

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    assign wheel_edge_c = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= 3'b000;
            cnt_q           <= '0;
            ten_meter_pulse <= 1'b0;
        end else begin
            sync_q          <= {sync_q[1:0], wheel_raw};
            ten_meter_pulse <= 1'b0;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (count_en && wheel_edge_c) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q           <= '0;
                    ten_meter_pulse <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/trip_ctrl.sv
// Taxi-meter trip sequencer: IDLE/CLR/RUN/WAIT/DONE control, stall and wait-minute timing.
// Build option NIGHT_RATE_EN selects the tariff from the night input at trip start.
module trip_ctrl
    import taxi_pkg::*;
#(
    parameter int unsigned         PULSES_PER_10M = 4,
    parameter logic [STALL_W-1:0]  STALL_CYCLES   = 24'd500000,
    parameter logic [FARE_W-1:0]   DAY_RATE       = DEF_DAY_RATE,
    parameter logic [FARE_W-1:0]   NIGHT_RATE     = DEF_NIGHT_RATE,
    parameter logic [FARE_W-1:0]   START_FARE     = DEF_START_FARE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_key,
    input  logic               stop_key,
    input  logic               wheel_raw,
    input  logic               night,
    input  logic               max,
    input  logic               sec_tick,
    output logic               meter_clr_n,
    output logic               en,
    output logic               wait_en,
    output logic               ten_meter_pulse,
    output logic               wait_min_pulse,
    output logic [FARE_W-1:0]  per_pulse_fare,
    output logic [FARE_W-1:0]  s_fare,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [STALL_W-1:0] STALL_LAST = STALL_CYCLES - 24'd1;
    localparam logic [5:0]         WSEC_LAST  = 6'(SECS_PER_MIN - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STALL_W-1:0] stall_q;
    logic [5:0]         wsec_q;
    logic               wheel_edge_c;
    logic               stall_hit_c;
    logic [FARE_W-1:0]  rate_c;

    wheel_sync #(
        .PULSES_PER_10M (PULSES_PER_10M)
    ) u_wheel_sync (
        .clk             (clk),
        .rst_n           (rst_n),
        .wheel_raw       (wheel_raw),
        .count_en        (state_q == ST_RUN),
        .cnt_clr         (state_q == ST_CLR),
        .wheel_edge_c    (wheel_edge_c),
        .ten_meter_pulse (ten_meter_pulse)
    );

`ifdef NIGHT_RATE_EN
    assign rate_c = night ? NIGHT_RATE : DAY_RATE;
`else
    logic unused_cfg;
    assign unused_cfg = ^{night, NIGHT_RATE};
    assign rate_c     = DAY_RATE;
`endif

    assign stall_hit_c = (stall_q >= STALL_LAST);
    assign s_fare      = START_FARE;
    assign state_o     = state_q;

    // Next state; priority max > stop_key > start_key > wheel/stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_key && !stop_key) state_d = ST_CLR;
            ST_CLR:  state_d = ST_RUN;
            ST_RUN: begin
                if (max || stop_key)                  state_d = ST_DONE;
                else if (!wheel_edge_c && stall_hit_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (max || stop_key)  state_d = ST_DONE;
                else if (wheel_edge_c) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (stop_key)       state_d = ST_IDLE;
                else if (start_key) state_d = ST_CLR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered control decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            meter_clr_n    <= 1'b1;
            en             <= 1'b0;
            wait_en        <= 1'b0;
            per_pulse_fare <= DAY_RATE;
        end else begin
            state_q     <= state_d;
            meter_clr_n <= (state_d != ST_CLR);
            en          <= (state_d == ST_RUN) || (state_d == ST_WAIT);
            wait_en     <= (state_d == ST_WAIT);
            if (state_q == ST_CLR) per_pulse_fare <= rate_c;
        end
    end

    // Saturating stall timer, restarted by wheel edges and on entering RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == ST_CLR) || wheel_edge_c ||
                     ((state_d == ST_RUN) && (state_q != ST_RUN))) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    // Wait-seconds counter persists across RUN/WAIT; only a new trip clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsec_q         <= '0;
            wait_min_pulse <= 1'b0;
        end else begin
            wait_min_pulse <= 1'b0;
            if (state_q == ST_CLR) begin
                wsec_q <= '0;
            end else if ((state_q == ST_WAIT) && sec_tick) begin
                if (wsec_q == WSEC_LAST) begin
                    wsec_q         <= '0;
                    wait_min_pulse <= 1'b1;
                end else begin
                    wsec_q <= wsec_q + 6'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trip_ctrl.sv
// Scoreboard bench for trip_ctrl: stimulus queues expected snapshots and strobes, a monitor checks them.
module tb_trip_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_key;
    logic        stop_key;
    logic        wheel_raw;
    logic        night;
    logic        max;
    logic        sec_tick;
    logic        meter_clr_n;
    logic        en;
    logic        wait_en;
    logic        ten_meter_pulse;
    logic        wait_min_pulse;
    logic [11:0] per_pulse_fare;
    logic [11:0] s_fare;
    logic [2:0]  state_o;

    trip_ctrl #(
        .PULSES_PER_10M (4),
        .STALL_CYCLES   (24'd100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_key       (start_key),
        .stop_key        (stop_key),
        .wheel_raw       (wheel_raw),
        .night           (night),
        .max             (max),
        .sec_tick        (sec_tick),
        .meter_clr_n     (meter_clr_n),
        .en              (en),
        .wait_en         (wait_en),
        .ten_meter_pulse (ten_meter_pulse),
        .wait_min_pulse  (wait_min_pulse),
        .per_pulse_fare  (per_pulse_fare),
        .s_fare          (s_fare),
        .state_o         (state_o)
    );

    localparam logic [2:0] IDLE = 3'd0, CLR = 3'd1, RUN = 3'd2, WAIT = 3'd3, DONE = 3'd4;

    typedef struct {
        int          cyc;
        string       name;
        logic [29:0] vec;
    } chk_t;

    chk_t        cq[$];
    int          tq[$];
    int          wq[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [11:0] exp_ppf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [11:0] rate_for(input logic n);
`ifdef NIGHT_RATE_EN
        return n ? 12'h030 : 12'h020;
`else
        return (n === 1'bx) ? 12'hxxx : 12'h020;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input string name, input logic [2:0] st,
                             input logic e, input logic w, input logic c, input logic [11:0] ppf);
        chk_t x;
        x.cyc  = at;
        x.name = name;
        x.vec  = {st, e, w, c, ppf, 12'h100};
        cq.push_back(x);
    endtask

    task automatic wheel_edge(input bit expect_strobe);
        wheel_raw = 1'b1;
        if (expect_strobe) tq.push_back(cyc + 3);
        repeat (3) tick();
        wheel_raw = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: compares queued snapshots and every strobe the DUT presents
    always @(negedge clk) begin
        chk_t        e;
        logic [29:0] act;
        act = {state_o, en, wait_en, meter_clr_n, per_pulse_fare, s_fare};
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            e = cq.pop_front();
            checks++;
            if (e.cyc != cyc || act !== e.vec) begin
                errors++;
                $display("FAIL %s cyc %0d: got st/en/wen/clrn/ppf/sfare=%h expected %h (due cyc %0d)",
                         e.name, cyc, act, e.vec, e.cyc);
            end
        end
        while (tq.size() > 0 && tq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL ten_meter_missing: no strobe at cyc %0d", tq.pop_front());
        end
        while (wq.size() > 0 && wq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL wait_min_missing: no strobe at cyc %0d", wq.pop_front());
        end
        if (ten_meter_pulse === 1'b1) begin
            checks++;
            if (tq.size() == 0 || tq[0] != cyc) begin
                errors++;
                $display("FAIL ten_meter_pulse: strobe at cyc %0d, expected cyc %0d",
                         cyc, (tq.size() > 0) ? tq[0] : -1);
            end else begin
                void'(tq.pop_front());
            end
        end
        if (wait_min_pulse === 1'b1) begin
            checks++;
            if (wq.size() == 0 || wq[0] != cyc) begin
                errors++;
                $display("FAIL wait_min_pulse: strobe at cyc %0d, expected cyc %0d",
                         cyc, (wq.size() > 0) ? wq[0] : -1);
            end else begin
                void'(wq.pop_front());
            end
        end
    end

    initial begin
        int c0;
        int n0;
        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b0; start_key = 1'b0; stop_key = 1'b0; wheel_raw = 1'b0;
        night = 1'b0; max = 1'b0; sec_tick = 1'b0;
        exp_ppf = 12'h020;
        tick(); tick();
        expect_at(cyc, "reset", IDLE, 1'b0, 1'b0, 1'b1, 12'h020);
        rst_n = 1'b1;
        tick();

        // T1: start -> one CLR cycle -> RUN
        start_key = 1'b1; tick(); start_key = 1'b0;
        exp_ppf = rate_for(night);
        expect_at(cyc,     "t1_clr",  CLR, 1'b0, 1'b0, 1'b0, 12'h020);
        expect_at(cyc + 1, "t1_run",  RUN, 1'b1, 1'b0, 1'b1, exp_ppf);
        expect_at(cyc + 2, "t1_run2", RUN, 1'b1, 1'b0, 1'b1, exp_ppf);
        tick();

        // T2: 8 edges -> strobes on the 4th and 8th
        for (int i = 0; i < 8; i++) wheel_edge(i == 3 || i == 7);
        expect_at(cyc, "t2_run", RUN, 1'b1, 1'b0, 1'b1, exp_ppf);
        stop_key = 1'b1; tick(); stop_key = 1'b0;
        expect_at(cyc, "t2_done", DONE, 1'b0, 1'b0, 1'b1, exp_ppf);
        tick();

        // T5/T3: night trip, stall into WAIT, wait minutes, edge back to RUN
        night = 1'b1;
        start_key = 1'b1; tick(); start_key = 1'b0;
        c0 = cyc;
        expect_at(c0, "t5_clr", CLR, 1'b0, 1'b0, 1'b0, exp_ppf);
        exp_ppf = rate_for(1'b1);
        expect_at(c0 + 1, "t5_ppf", RUN, 1'b1, 1'b0, 1'b1, exp_ppf);
        tick();
        night = 1'b0;
        expect_at(c0 + 100, "t3_last_run", RUN,  1'b1, 1'b0, 1'b1, exp_ppf);
        expect_at(c0 + 101, "t3_wait",     WAIT, 1'b1, 1'b1, 1'b1, exp_ppf);
        while (cyc < c0 + 101) tick();
        for (int i = 0; i < 120; i++) begin
            sec_tick = 1'b1;
            if (i == 59 || i == 119) wq.push_back(cyc + 1);
            tick();
            sec_tick = 1'b0;
            tick();
        end
        expect_at(cyc, "t3_wait_held", WAIT, 1'b1, 1'b1, 1'b1, exp_ppf);
        n0 = cyc;
        expect_at(n0 + 2, "t3_edge_pending", WAIT, 1'b1, 1'b1, 1'b1, exp_ppf);
        expect_at(n0 + 3, "t3_back_run",     RUN,  1'b1, 1'b0, 1'b1, exp_ppf);
        wheel_edge(1'b0);
        for (int i = 0; i < 4; i++) wheel_edge(i == 3);
        repeat (110) tick();
        expect_at(cyc, "t4_pre_wait", WAIT, 1'b1, 1'b1, 1'b1, exp_ppf);

        // T4: max with start in WAIT -> DONE; stop -> IDLE; start+stop in IDLE stays IDLE
        max = 1'b1; start_key = 1'b1; tick(); max = 1'b0; start_key = 1'b0;
        expect_at(cyc, "t4_done", DONE, 1'b0, 1'b0, 1'b1, exp_ppf);
        tick();
        stop_key = 1'b1; tick(); stop_key = 1'b0;
        expect_at(cyc, "t4_idle", IDLE, 1'b0, 1'b0, 1'b1, exp_ppf);
        tick();
        start_key = 1'b1; stop_key = 1'b1; tick(); start_key = 1'b0; stop_key = 1'b0;
        expect_at(cyc, "start_stop_idle", IDLE, 1'b0, 1'b0, 1'b1, exp_ppf);
        tick();

        // T6: asynchronous reset mid-RUN
        night = 1'b1;
        start_key = 1'b1; tick(); start_key = 1'b0;
        exp_ppf = rate_for(1'b1);
        tick(); tick();
        expect_at(cyc, "t6_run", RUN, 1'b1, 1'b0, 1'b1, exp_ppf);
        tick();
        expect_at(cyc, "t6_async_rst", IDLE, 1'b0, 1'b0, 1'b1, 12'h020);
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1; night = 1'b0;
        tick();
        expect_at(cyc, "t6_after_rst", IDLE, 1'b0, 1'b0, 1'b1, 12'h020);
        repeat (3) tick();

        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL snapshot_queue: %0d left, expected 0", cq.size());
        end
        checks++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL ten_meter_queue: %0d left, expected 0", tq.size());
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL wait_min_queue: %0d left, expected 0", wq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
